// File: rtl/seqmon_pkg.sv
// Shared widths and state encoding for the windowed match-rate monitor.
package seqmon_pkg;

  localparam int COUNT_W = 16;
  localparam int WCNT_W  = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'h0;
  localparam state_t RUN  = 2'h1;

endpackage

// File: rtl/seqmon_window_timer.sv
// Window cycle counter: counts 0..WINDOW-1 while enabled, flags the last cycle.
module seqmon_window_timer
  import seqmon_pkg::*;
#(
  parameter int unsigned WINDOW = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WINDOW - 1);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  assign tick_o = (wcnt_q == LAST);

  always_comb begin
    wcnt_d = wcnt_q;
    if (clr_i) begin
      wcnt_d = '0;
    end else if (en_i) begin
      wcnt_d = tick_o ? '0 : wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/seqdec_rate_mon.sv
// Windowed rate monitor over the sequence detector's running match count.
// Optional peak tracking is built when SEQMON_PEAK_EN is defined.
module seqdec_rate_mon
  import seqmon_pkg::*;
#(
  parameter int unsigned        WINDOW = 256,
  parameter logic [COUNT_W-1:0] THRESH = 16'd64
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               En,
  input  logic [COUNT_W-1:0] Count,
  input  logic               Ready,
  output logic [COUNT_W-1:0] Rate,
  output logic               Alarm,
  output logic               Valid,
  output logic               Overrun
`ifdef SEQMON_PEAK_EN
  ,
  output logic [COUNT_W-1:0] Peak
`endif
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] base_q, base_d;
  logic [COUNT_W-1:0] rate_q, rate_d;
  logic               alarm_q, alarm_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               run, start, close, tick;
  logic [COUNT_W-1:0] delta;

  assign run   = (state_q == RUN) && En;
  assign start = (state_q == IDLE) && En;
  assign close = run && tick;
  // Modulo-2^16 difference is exact: a window never spans 65536 increments.
  assign delta = Count - base_q;

  seqmon_window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .clr_i  (!run),
    .en_i   (run),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rate_d  = rate_q;
    alarm_d = alarm_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (En) begin
          state_d = RUN;
          base_d  = Count;
          ovr_d   = 1'b0;
        end
      end
      RUN: begin
        if (!En) state_d = IDLE;
        else if (close) base_d = Count;
      end
      default: state_d = IDLE;
    endcase
    // A close with a held, unaccepted result drops the new delta.
    if (close) begin
      if (!valid_q || Ready) begin
        rate_d  = delta;
        alarm_d = (delta >= THRESH);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      rate_q  <= '0;
      alarm_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rate_q  <= rate_d;
      alarm_q <= alarm_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Rate    = rate_q;
  assign Alarm   = alarm_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;

`ifdef SEQMON_PEAK_EN
  logic [COUNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (start) peak_d = '0;
    else if (close && (delta > peak_q)) peak_d = delta;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign Peak = peak_q;
`endif

endmodule

// File: tb/tb_seqdec_rate_mon.sv
// Directed bench for seqdec_rate_mon with a result scoreboard (WINDOW=8, THRESH=4).
module tb_seqdec_rate_mon;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        En;
  logic [15:0] Count;
  logic        Ready;
  logic [15:0] Rate;
  logic        Alarm;
  logic        Valid;
  logic        Overrun;
`ifdef SEQMON_PEAK_EN
  logic [15:0] Peak;
`endif

  seqdec_rate_mon #(.WINDOW(8), .THRESH(16'd4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (En),
    .Count   (Count),
    .Ready   (Ready),
    .Rate    (Rate),
    .Alarm   (Alarm),
    .Valid   (Valid),
    .Overrun (Overrun)
`ifdef SEQMON_PEAK_EN
    ,
    .Peak    (Peak)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] rate;
    logic        alarm;
  } res_t;

  res_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] r);
    res_t e;
    e.rate  = r;
    e.alarm = (r >= 16'd4);
    q.push_back(e);
  endtask

  // One clock: score a handshake that will complete at the coming edge, then advance.
  task automatic cyc();
    res_t e;
    if (Valid === 1'b1 && Ready === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_unexpected_result", 32'(Rate), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("sb_rate", 32'(Rate), 32'(e.rate));
        check("sb_alarm", 32'(Alarm), 32'(e.alarm));
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_window(input logic [15:0] b, input logic [15:0] e, input bit chk_pre);
    Count = b;
    En    = 1'b1;
    cyc();
    Count = e;
    repeat (7) cyc();
    if (chk_pre) check("valid_before_close", 32'(Valid), 32'd0);
    cyc();
  endtask

  initial begin
    Reset_n = 1'b0;
    En      = 1'b0;
    Count   = 16'h0010;
    Ready   = 1'b1;
    #2;
    check("rst_rate", 32'(Rate), 32'd0);
    check("rst_alarm", 32'(Alarm), 32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
`ifdef SEQMON_PEAK_EN
    check("rst_peak", 32'(Peak), 32'd0);
`endif
    cyc();
    cyc();
    Reset_n = 1'b1;
    repeat (2) cyc();
    check("idle_valid", 32'(Valid), 32'd0);

    // Basic window 0x10 -> 0x13
    push(16'd3);
    run_window(16'h0010, 16'h0013, 1'b1);
    check("basic_valid", 32'(Valid), 32'd1);
    check("basic_rate", 32'(Rate), 32'd3);
    check("basic_alarm", 32'(Alarm), 32'd0);
    En = 1'b0;
    cyc();
    check("basic_pulse_end", 32'(Valid), 32'd0);

    // Wrap-around 0xFFFE -> 0x0003
    push(16'd5);
    run_window(16'hFFFE, 16'h0003, 1'b1);
    check("wrap_rate", 32'(Rate), 32'd5);
    check("wrap_alarm", 32'(Alarm), 32'd1);
    En = 1'b0;
    cyc();

    // Overrun: second close dropped while Ready is low
    Ready = 1'b0;
    push(16'd6);
    run_window(16'h0100, 16'h0106, 1'b1);
    Count = 16'h0108;
    repeat (8) cyc();
    check("ovr_valid", 32'(Valid), 32'd1);
    check("ovr_rate", 32'(Rate), 32'd6);
    check("ovr_alarm", 32'(Alarm), 32'd1);
    check("ovr_flag", 32'(Overrun), 32'd1);
    En    = 1'b0;
    Ready = 1'b1;
    cyc();
    check("ovr_accept_valid", 32'(Valid), 32'd0);
    check("ovr_sticky", 32'(Overrun), 32'd1);

    // Simultaneous accept and close
    Ready = 1'b0;
    push(16'd3);
    run_window(16'h0200, 16'h0203, 1'b1);
    check("sim_ovr_cleared", 32'(Overrun), 32'd0);
    Count = 16'h020A;
    repeat (7) cyc();
    Ready = 1'b1;
    push(16'd7);
    cyc();
    check("sim_valid", 32'(Valid), 32'd1);
    check("sim_rate", 32'(Rate), 32'd7);
    check("sim_overrun", 32'(Overrun), 32'd0);
    En = 1'b0;
    cyc();
    check("sim_done_valid", 32'(Valid), 32'd0);

    // En dropped mid-window after an overrun, then re-enable
    Ready = 1'b0;
    push(16'd1);
    run_window(16'h0300, 16'h0301, 1'b1);
    Count = 16'h0302;
    repeat (8) cyc();
    check("drop_ovr_set", 32'(Overrun), 32'd1);
    repeat (3) cyc();
    En    = 1'b0;
    Count = 16'h0350;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("drop_no_new_rate", 32'(Rate), 32'd1);
    end
    Ready = 1'b1;
    cyc();
    check("drop_accept_valid", 32'(Valid), 32'd0);
    check("drop_ovr_sticky", 32'(Overrun), 32'd1);
    push(16'd9);
    run_window(16'h0400, 16'h0409, 1'b1);
    check("reen_ovr_cleared", 32'(Overrun), 32'd0);
    check("reen_rate", 32'(Rate), 32'd9);
    En = 1'b0;
    cyc();

    // Back-to-back windows with deltas 3, 9, 4
    Ready = 1'b1;
    push(16'd3);
    run_window(16'h0600, 16'h0603, 1'b1);
    Count = 16'h060C;
    push(16'd9);
    repeat (8) cyc();
    Count = 16'h0610;
    push(16'd4);
    repeat (8) cyc();
    check("b2b_rate", 32'(Rate), 32'd4);
`ifdef SEQMON_PEAK_EN
    check("peak_value", 32'(Peak), 32'd9);
`endif
    En = 1'b0;
    cyc();

    // Async reset mid-window with a pending result and overrun
    Ready = 1'b0;
    push(16'd4);
    run_window(16'h0700, 16'h0704, 1'b1);
    Count = 16'h0706;
    repeat (8) cyc();
    repeat (3) cyc();
    check("prerst_valid", 32'(Valid), 32'd1);
    check("prerst_overrun", 32'(Overrun), 32'd1);
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(Valid), 32'd0);
    check("arst_rate", 32'(Rate), 32'd0);
    check("arst_alarm", 32'(Alarm), 32'd0);
    check("arst_overrun", 32'(Overrun), 32'd0);
`ifdef SEQMON_PEAK_EN
    check("arst_peak", 32'(Peak), 32'd0);
`endif
    q.delete();
    En = 1'b0;
    cyc();
    Reset_n = 1'b1;
    Ready   = 1'b1;
    repeat (12) cyc();
    check("post_rst_idle_valid", 32'(Valid), 32'd0);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seqdec_rate_mon.md
# seqdec_rate_mon

Windowed rate monitor placed directly downstream of the sequence detector. It samples that block's 16-bit running match count and reports the number of matches in each fixed window of WINDOW cycles. Each result carries a threshold alarm and is returned over a valid/ready handshake to the host or control logic.

## Interface
- WINDOW, 256: window length in Clk cycles; legal range 2..65535.
- THRESH, 16'd64: alarm threshold; alarm when window delta >= THRESH.

- Clk  in  1  sole clock; all state updates on rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- En  in  1  monitor enable; 1 = run windows back-to-back, 0 = abandon current window and return to IDLE.
- Count  in  16  running match count from the sequence detector (free-running, wraps 0xFFFF->0x0000).
- Ready  in  1  consumer accepts the result when Ready && Valid at a rising edge.
- Rate  out  16  match count of the last reported window.
- Alarm  out  1  Rate >= THRESH, qualified with Rate.
- Valid  out  1  Rate/Alarm hold an unaccepted result.
- Overrun  out  1  sticky; a window result was dropped because the previous one was not accepted.
- Peak  out  16  largest window delta since start (only with SEQMON_PEAK_EN).

## Operation
- States: IDLE (2'h0), RUN (2'h1); other encodings -> IDLE next cycle.
- Reset (Reset_n=0, immediate): state=IDLE, window counter=0, base=0, Rate=0, Alarm=0, Valid=0, Overrun=0, Peak=0.
- IDLE, En=1: base<=Count, wcnt<=0, Overrun<=0, Peak<=0, go RUN. Valid/Rate are not touched.
- RUN, En=1, wcnt<WINDOW-1: wcnt<=wcnt+1.
- RUN, En=1, wcnt==WINDOW-1 (window close): delta=Count-base modulo 2^16; base<=Count; wcnt<=0; stay RUN with no idle cycle between windows.
- Result load at window close:
  - Valid=0, or Valid=1 && Ready=1: Rate<=delta, Alarm<=(delta>=THRESH), Valid<=1.
  - Valid=1 && Ready=0: delta is dropped; Rate/Alarm are unchanged; Overrun<=1.
- Accept without a window close: Valid && Ready -> Valid<=0; Rate/Alarm keep their last value.
- RUN, En=0: go IDLE and discard the partial window. A pending Valid result stays until it is accepted.
- Arithmetic: 16-bit unsigned subtraction, with no special case for Count wrap. The result is exact because fewer than 65536 increments can occur in a window.

## Timing
- Base is captured at the IDLE->RUN edge E. Results are computed at edges E+WINDOW, E+2*WINDOW, and so on.
- Rate/Alarm/Valid are registered. They are visible in the cycle after the closing edge, i.e. 1-cycle latency from the Count sample.
- Count is sampled only at the entry and closing edges and must be synchronous to Clk.
- Valid rises no earlier than WINDOW cycles after En is seen high.
- Back-to-back accept: Ready held at 1 gives one Valid pulse of 1 cycle per window.
- Reset_n asserted mid-window clears everything at once, including a pending result. After release, the block waits in IDLE for En.

## Configuration
- SEQMON_PEAK_EN defined:
  - Peak register and Peak port are present.
  - At every window close, including a dropped overrun result: Peak<=max(Peak, delta).
  - Peak clears on reset and on IDLE->RUN.
- SEQMON_PEAK_EN undefined: no Peak port and no Peak register; all other behaviour is identical.

## Structure
- Package seqmon_pkg contains:
  - COUNT_W=16.
  - State typedef with IDLE=2'h0, RUN=2'h1.
  - Helper constant for the WINDOW counter width (16).
- One sub-module, seqmon_window_timer:
  - wcnt register with clear/enable inputs.
  - Terminal-tick output at WINDOW-1.
- The top level holds the FSM, base/result registers, handshake and peak logic.

## Test plan
- Reset and basic window: WINDOW=8, THRESH=4, Ready=1, En=1. Count goes 0x0010 -> 0x0013 over the window. Expected: Rate=3, Alarm=0, Valid=1 for one cycle, 9 cycles after the En edge.
- Wrap-around: base Count=0xFFFE, Count at close=0x0003. Expected: Rate=5, Alarm=1.
- Overrun: Ready=0 across two closes with deltas 6 then 2. Expected: Rate stays 6, Valid=1, Overrun=1. After Ready=1, Valid drops.
- Simultaneous accept and close: Valid=1, Ready=1 on the closing edge with delta 7. Expected: Rate=7, Valid stays 1, Overrun=0.
- En dropped mid-window (wcnt=3): return to IDLE with no new result. Re-enable: Overrun clears, and the next result covers a full WINDOW from the new base.
- Async reset mid-window with a pending result: all outputs go to 0 without a clock edge. With SEQMON_PEAK_EN, deltas 3, 9, 4 give Peak=9.
